gpu_cmd_tx: RTL

//  CPU-side initiator for the GPU command interface. Accepts commands from the bus over a

---
 rtl/gpu_cmd_tx.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_tx.sv
// CPU-side initiator for the GPU command port: buffers bus commands in a FIFO and
// replays them as cmd/data/strobe with setup and hold, tracking a shadow text cursor.
module gpu_cmd_tx #(
  parameter int FIFO_DEPTH    = 8,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [1:0] gpu_cmd_out,
  output logic [7:0] gpu_data_out,
  output logic       gpu_strobe_out,
  output logic       busy,
  output logic [6:0] shadow_x,
  output logic [5:0] shadow_y
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] SETUP_LAST  = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] STROBE_LAST = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  typedef enum logic [2:0] {
    OP_STORE   = 3'b000,
    OP_MOVE    = 3'b001,
    OP_DISPLAY = 3'b010,
    OP_CLEAR   = 3'b011,
    OP_SET_ABS = 3'b100
  } op_t;

  // ---------------------------------------------------------------- FIFO
  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, empty, full;
  logic [2:0]    head_op;
  logic [7:0]    head_data;
  logic          head_known;

  assign empty      = (count == '0);
  assign full       = (count == DEPTH_C);
  assign cmd_ready  = ~full;
  assign push       = cmd_valid & cmd_ready;
  assign head_op    = mem[rd_ptr][10:8];
  assign head_data  = mem[rd_ptr][7:0];
  assign head_known = (head_op <= OP_SET_ABS);

  // NOTE: payload storage is deliberately not reset; validity is carried entirely by
  // count, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_data};
  end

  // NOTE: every register is written with <= so all state updates see pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ----------------------------------------------------------- sequencer
  state_t        state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic          load;

  // NOTE: all outputs of this block get a default before the case so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_known) begin
            load    = 1'b1;
            state_n = SETUP;
            cnt_n   = SETUP_LAST;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = STROBE;
          cnt_n   = STROBE_LAST;
        end else begin
          cnt_n = cnt - TW'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = HOLD_LAST;
        end else begin
          cnt_n = cnt - TW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = IDLE;
          // Chain straight into the next command so the GPU sees no extra idle cycle.
          if (!empty) begin
            pop = 1'b1;
            if (head_known) begin
              load    = 1'b1;
              state_n = SETUP;
              cnt_n   = SETUP_LAST;
            end
          end
        end else begin
          cnt_n = cnt - TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ------------------------------------------- translation and shadow cursor
  logic [1:0] xlat_cmd;
  logic [7:0] xlat_data;
  logic [6:0] x_n;
  logic [5:0] y_n;

  always_comb begin
    xlat_cmd  = 2'b00;
    xlat_data = head_data;
    x_n       = shadow_x;
    y_n       = shadow_y;
    case (head_op)
      OP_STORE: begin
        xlat_cmd = 2'b00;
        // The GPU wraps its text cursor after column 80 and row 60.
        if (shadow_x == 7'd80) begin
          x_n = 7'd0;
          y_n = (shadow_y == 6'd60) ? 6'd0 : shadow_y + 6'd1;
        end else begin
          x_n = shadow_x + 7'd1;
        end
      end
      OP_MOVE: begin
        xlat_cmd = 2'b01;
        if (head_data[7]) x_n = shadow_x + head_data[6:0];
        else              y_n = shadow_y + head_data[5:0];
      end
      OP_DISPLAY: xlat_cmd = 2'b10;
      OP_CLEAR:   xlat_cmd = 2'b11;
      OP_SET_ABS: begin
        xlat_cmd = 2'b01;
        if (head_data[7]) begin
          xlat_data = {1'b1, head_data[6:0] - shadow_x};
          x_n       = head_data[6:0];
        end else begin
          xlat_data = {2'b00, head_data[5:0] - shadow_y};
          y_n       = head_data[5:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      gpu_cmd_out    <= '0;
      gpu_data_out   <= '0;
      gpu_strobe_out <= 1'b0;
      shadow_x       <= '0;
      shadow_y       <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      // Strobe is registered from the next state so the GPU edge is glitch-free.
      gpu_strobe_out <= (state_n == STROBE);
      if (load) begin
        gpu_cmd_out  <= xlat_cmd;
        gpu_data_out <= xlat_data;
        shadow_x     <= x_n;
        shadow_y     <= y_n;
      end
    end
  end

  assign busy = (state != IDLE) | ~empty;

endmodule
